// File: rtl/chan_pkg.sv
// Shared constants and read-FSM encodings for the channelizer
// output reorder buffer.
package chan_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int FFT_SIZE_WIDTH_DEF = 12;
  localparam int ADDR_WIDTH = FFT_SIZE_WIDTH_DEF - 1;
  localparam int OUT_FIFO_ADDR_WIDTH = 4;
  localparam int ALMOST_FULL_THRESH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ0 = 2'd1,
    S_READ1 = 2'd2
  } rd_state_e;

endpackage

// File: rtl/chan_out_buffer_if.sv
// AXI-stream style bundle: tvalid/tready handshake with data,
// channel/bin index in tuser and an end-of-frame tlast.
interface chan_out_buffer_if #(
  parameter int DW = 32,
  parameter int UW = 11
) ();

  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic [UW-1:0] tuser;
  logic          tlast;

  modport master (
    output tvalid, tdata, tuser, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tuser, tlast,
    output tready
  );

endinterface

// File: rtl/axi_fifo_19.sv
// Show-ahead stream FIFO with occupancy count.
// in_* is the write side, out_* the read side.
module axi_fifo_19 #(
  parameter int WIDTH = 19,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wp, rp;
  logic                  push, pop;

  assign out_valid = (count != '0);
  assign out_data  = mem[rp];
  assign push      = in_valid & (count != (ADDR_WIDTH+1)'(DEPTH));
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp] <= in_data;
        wp      <= wp + ADDR_WIDTH'(1);
      end
      if (pop) rp <= rp + ADDR_WIDTH'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/chan_neg_sat.sv
// Per-half two's complement negate; the most negative value
// saturates to the most positive. din/dout = {Q, I}.
module chan_neg_sat #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int HW = DATA_WIDTH / 2;

  localparam logic [HW-1:0] MIN_V = {1'b1, {(HW-1){1'b0}}};
  localparam logic [HW-1:0] MAX_V = {1'b0, {(HW-1){1'b1}}};

  logic [HW-1:0] i_in, q_in;
  logic [HW-1:0] i_out, q_out;

  assign i_in  = din[HW-1:0];
  assign q_in  = din[DATA_WIDTH-1:HW];
  assign i_out = (i_in == MIN_V) ? MAX_V : -i_in;
  assign q_out = (q_in == MIN_V) ? MAX_V : -q_in;
  assign dout  = {q_out, i_out};

endmodule

// File: rtl/dp_block_read_first_ram.sv
// Simple dual-port block RAM, one write port, one registered
// read port (read-first on address collision).
module dp_block_read_first_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [1<<ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/chan_out_buffer.sv
// Ping-pong reorder buffer after the FFT: bins in any order, channels
// out 0..fft_size-1 with odd-frame odd-bin negation. s_axis in, m_axis out.
module chan_out_buffer
  import chan_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FFT_SIZE_WIDTH = FFT_SIZE_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      sync_reset_n,
  input  logic [FFT_SIZE_WIDTH-1:0] fft_size,
  chan_out_buffer_if.slave          s_axis,
  chan_out_buffer_if.master         m_axis
);

  localparam int AW = FFT_SIZE_WIDTH - 1;
  localparam int DW = DATA_WIDTH;
  localparam int EW = DW + AW + 1;
  localparam int CW = OUT_FIFO_ADDR_WIDTH + 1;

  logic          unused_size_msb;
  logic [AW-1:0] size_mask;

  assign {unused_size_msb, size_mask} =
    fft_size - FFT_SIZE_WIDTH'(1);

  logic [1:0]    full, full_nxt;
  logic          wr_side, frame_odd, wr_busy;
  logic [AW-1:0] wr_mask_q, wr_mask, wr_addr;
  logic [DW-1:0] neg_data, wr_data;
  logic          wr_fire, wr_end, rd_done;

  rd_state_e     state;
  logic          rd_side;
  logic [AW-1:0] rd_ptr, rd_mask;
  logic          almost_full, issue, rd_last;

  logic [DW-1:0] ram0_q, ram1_q;

  logic          p1_valid, p1_side, p1_last;
  logic [AW-1:0] p1_ch;
  logic          tag_valid, tag_last;
  logic [AW-1:0] tag_ch;
  logic [DW-1:0] tag_data;

  logic [EW-1:0] fifo_q;
  logic [CW-1:0] fifo_count;

  assign s_axis.tready = ~full[wr_side];
  assign wr_fire = s_axis.tvalid & s_axis.tready;
  assign wr_end  = wr_fire & s_axis.tlast;

  // Mask is latched on the first bin so a mid-frame size
  // change only applies from the next frame.
  assign wr_mask = wr_busy ? wr_mask_q : size_mask;
  assign wr_addr = s_axis.tuser & wr_mask;

  chan_neg_sat #(
    .DATA_WIDTH(DW)
  ) u_neg (
    .din  (s_axis.tdata),
    .dout (neg_data)
  );

  assign wr_data = (frame_odd & s_axis.tuser[0]) ?
                   neg_data : s_axis.tdata;

  always_comb begin
    full_nxt = full;
    if (rd_done) full_nxt[rd_side] = 1'b0;
    if (wr_end)  full_nxt[wr_side] = 1'b1;
  end

  always_ff @(posedge clk or negedge sync_reset_n) begin
    if (!sync_reset_n) begin
      full      <= '0;
      wr_side   <= 1'b0;
      frame_odd <= 1'b0;
      wr_busy   <= 1'b0;
      wr_mask_q <= '0;
    end else begin
      full <= full_nxt;
      if (wr_fire) begin
        if (!wr_busy) wr_mask_q <= size_mask;
        wr_busy <= ~s_axis.tlast;
      end
      if (wr_end) begin
        wr_side   <= ~wr_side;
        frame_odd <= ~frame_odd;
      end
    end
  end

  // Issue pauses while the output FIFO is near full; at most
  // three reads are in flight so the FIFO never overflows.
  assign almost_full = fifo_count >= CW'(ALMOST_FULL_THRESH);
  assign issue   = (state != S_IDLE) & ~almost_full;
  assign rd_last = (rd_ptr == rd_mask);
  assign rd_done = issue & rd_last;

  always_ff @(posedge clk or negedge sync_reset_n) begin
    if (!sync_reset_n) begin
      state   <= S_IDLE;
      rd_side <= 1'b0;
      rd_ptr  <= '0;
      rd_mask <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (full[rd_side] & ~almost_full) begin
            state   <= rd_side ? S_READ1 : S_READ0;
            rd_ptr  <= '0;
            rd_mask <= size_mask;
          end
        end
        S_READ0, S_READ1: begin
          if (issue) begin
            rd_ptr <= rd_ptr + AW'(1);
            if (rd_last) begin
              state   <= S_IDLE;
              rd_side <= ~rd_side;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  dp_block_read_first_ram #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) u_ram0 (
    .clk     (clk),
    .wr_en   (wr_fire & ~wr_side),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (issue),
    .rd_addr (rd_ptr),
    .rd_data (ram0_q)
  );

  dp_block_read_first_ram #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) u_ram1 (
    .clk     (clk),
    .wr_en   (wr_fire & wr_side),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (issue),
    .rd_addr (rd_ptr),
    .rd_data (ram1_q)
  );

  // p1 tracks the RAM read stage; tag selects the bank and
  // attaches channel number and tlast.
  always_ff @(posedge clk or negedge sync_reset_n) begin
    if (!sync_reset_n) begin
      p1_valid  <= 1'b0;
      p1_side   <= 1'b0;
      p1_ch     <= '0;
      p1_last   <= 1'b0;
      tag_valid <= 1'b0;
      tag_data  <= '0;
      tag_ch    <= '0;
      tag_last  <= 1'b0;
    end else begin
      p1_valid <= issue;
      if (issue) begin
        p1_side <= rd_side;
        p1_ch   <= rd_ptr;
        p1_last <= rd_last;
      end
      tag_valid <= p1_valid;
      if (p1_valid) begin
        tag_data <= p1_side ? ram1_q : ram0_q;
        tag_ch   <= p1_ch;
        tag_last <= p1_last;
      end
    end
  end

  axi_fifo_19 #(
    .WIDTH      (EW),
    .ADDR_WIDTH (OUT_FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (sync_reset_n),
    .in_valid  (tag_valid),
    .in_data   ({tag_last, tag_ch, tag_data}),
    .out_valid (m_axis.tvalid),
    .out_data  (fifo_q),
    .out_ready (m_axis.tready),
    .count     (fifo_count)
  );

  assign {m_axis.tlast, m_axis.tuser, m_axis.tdata} = fifo_q;

endmodule

// File: tb/tb_chan_out_buffer.sv
// Scoreboard bench for chan_out_buffer: the driver models the
// reorder/negation and queues expected channels; a monitor compares.
module tb_chan_out_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] fft_size = 12'd8;

  chan_out_buffer_if #(.DW(32), .UW(11)) s_if ();
  chan_out_buffer_if #(.DW(32), .UW(11)) m_if ();

  chan_out_buffer #(
    .DATA_WIDTH     (32),
    .FFT_SIZE_WIDTH (12)
  ) dut (
    .clk          (clk),
    .sync_reset_n (rst_n),
    .fft_size     (fft_size),
    .s_axis       (s_if),
    .m_axis       (m_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [10:0] u;
    logic        l;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] fbuf [2048];
  int          nassert = 0;
  int          nfail = 0;
  int          mon_cnt = 0;
  int          tl_cnt = 0;
  bit          model_odd = 1'b0;
  bit          t5_done = 1'b0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] req);
    nassert++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    nassert++;
    nfail++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic logic [31:0] corr(input logic [31:0] d);
    int i, q;
    i = -int'($signed(d[15:0]));
    q = -int'($signed(d[31:16]));
    if (i > 32767) i = 32767;
    if (q > 32767) q = 32767;
    return {q[15:0], i[15:0]};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
      mon_cnt++;
      if (exp_q.size() == 0) begin
        nassert++;
        nfail++;
        $display("FAIL unexpected_out: actual tuser=%0h required none",
                 m_if.tuser);
      end else begin
        e = exp_q.pop_front();
        check("out_tdata", 64'(m_if.tdata), 64'(e.d));
        check("out_tuser", 64'(m_if.tuser), 64'(e.u));
        check("out_tlast", 64'(m_if.tlast), 64'(e.l));
      end
    end
  end

  task automatic send_bin(input logic [31:0] d,
                          input logic [10:0] u,
                          input bit last);
    bit ok = 1'b0;
    bit to = 1'b0;
    int waitc = 0;
    logic [10:0] m;
    exp_t e;
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tuser  = u;
    s_if.tlast  = last;
    while (!ok && !to) begin
      @(negedge clk);
      if (s_if.tready === 1'b1) ok = 1'b1;
      @(posedge clk);
      #1;
      if (!ok) begin
        waitc++;
        if (waitc > 30000) begin
          fail_now("in_accept_timeout");
          to = 1'b1;
        end
      end
    end
    if (ok) begin
      m = 11'(fft_size - 12'd1);
      fbuf[u & m] = (model_odd && u[0]) ? corr(d) : d;
      if (last) begin
        for (int i = 0; i < int'(fft_size); i++) begin
          e.d = fbuf[i];
          e.u = 11'(i);
          e.l = (i == int'(fft_size) - 1);
          exp_q.push_back(e);
        end
        model_odd = ~model_odd;
        tl_cnt++;
      end
    end
  endtask

  task automatic idle_in();
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int base;
    int tl_base;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tuser  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    check("rst_m_tdata",  64'(m_if.tdata),  64'd0);
    check("rst_m_tuser",  64'(m_if.tuser),  64'd0);
    check("rst_m_tlast",  64'(m_if.tlast),  64'd0);
    check("rst_s_tready", 64'(s_if.tready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T1: reversed bin order, data = bin index
    fft_size = 12'd8;
    for (int i = 7; i >= 0; i--) send_bin(32'(i), 11'(i), i == 0);
    idle_in();
    lat = 0;
    while (m_if.tvalid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("t1_latency", 64'(lat), 64'd4);
    wait_drain(200, "t1_drain");

    // T2: odd frame, I=Q=100 -> odd channels become -100
    for (int i = 0; i < 8; i++)
      send_bin(32'h0064_0064, 11'(i), i == 7);
    idle_in();
    wait_drain(200, "t2_drain");

    // T3: even frame then odd frame with saturating bins
    for (int i = 0; i < 8; i++)
      send_bin(32'h0001_0001 * i, 11'(i), i == 7);
    for (int i = 0; i < 8; i++) begin
      if (i == 1)      send_bin(32'h0005_8000, 11'(i), 1'b0);
      else if (i == 3) send_bin(32'h8000_0003, 11'(i), 1'b0);
      else             send_bin(32'h0100_0200 + i, 11'(i), i == 7);
    end
    idle_in();
    wait_drain(200, "t3_drain");

    // T4: downstream stalled, 3 frames of 16
    fft_size = 12'd16;
    m_if.tready = 1'b0;
    base = mon_cnt;
    tl_base = tl_cnt;
    fork
      begin
        for (int f = 0; f < 3; f++)
          for (int i = 15; i >= 0; i--)
            send_bin(32'h1000_0000 * f + 32'h0003_0007 * i,
                     11'(i), i == 0);
        idle_in();
      end
      begin
        int c = 0;
        while (tl_cnt < tl_base + 2 && c < 5000) begin
          @(posedge clk);
          #1;
          c++;
        end
        if (c >= 5000) fail_now("t4_frame2_wait");
        repeat (20) @(posedge clk);
        #1;
        check("t4_in_stall", 64'(s_if.tready), 64'd0);
        check("t4_no_out", 64'(mon_cnt - base), 64'd0);
        m_if.tready = 1'b1;
      end
    join
    wait_drain(2000, "t4_drain");
    check("t4_count", 64'(mon_cnt - base), 64'd48);

    // T5: 2048 channels, 10 frames, random downstream ready
    fft_size = 12'd2048;
    base = mon_cnt;
    fork
      begin
        for (int f = 0; f < 10; f++)
          for (int i = 0; i < 2048; i++)
            send_bin($urandom, 11'(i) ^ 11'h2A5, i == 2047);
        idle_in();
        wait_drain(60000, "t5_drain");
        t5_done = 1'b1;
      end
      begin
        while (!t5_done) begin
          @(posedge clk);
          #1;
          m_if.tready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_if.tready = 1'b1;
    check("t5_count", 64'(mon_cnt - base), 64'd20480);

    // T6: reset with outputs pending and a partial frame
    fft_size = 12'd8;
    m_if.tready = 1'b0;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 8; i++)
        send_bin(32'h0200_0300 + i, 11'(i), i == 7);
    for (int i = 0; i < 4; i++)
      send_bin(32'h0064_0064, 11'(i), 1'b0);
    idle_in();
    repeat (5) @(posedge clk);
    #1;
    check("t6_pending", 64'(m_if.tvalid), 64'(exp_q.size() != 0));
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("t6_rst_tvalid", 64'(m_if.tvalid), 64'd0);
    end
    check("t6_rst_tready", 64'(s_if.tready), 64'd1);
    exp_q.delete();
    model_odd = 1'b0;
    m_if.tready = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++)
      send_bin(32'h0064_0064, 11'(i), i == 7);
    idle_in();
    wait_drain(200, "t6_drain");
    repeat (10) @(posedge clk);
    #1;
    check("t6_quiet", 64'(m_if.tvalid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nassert, nfail);
    $finish;
  end

endmodule
